// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, ALU/mux selects, FSM states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADDR   = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTE   = 4'd6,
    S_RCOMPL    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDIEXEC  = 4'd10,
    S_ADDICOMPL = 4'd11
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive stalled cycles in a memory-wait state and flags a timeout at WAIT_LIMIT.
module mem_wait_watchdog #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;
  logic             stalled;

  assign stalled = waiting && !mem_ready;
  assign timeout = (WAIT_LIMIT != 0) && stalled && !reset &&
                   (cnt == CNT_W'(WAIT_LIMIT));

  // A timeout forces a return to FETCH, so it restarts the count like any other exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (stalled && !timeout) begin
      // NOTE: state registers take <= so every flop samples pre-edge values together.
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle datapath: opcode decode, sequencing and datapath strobes.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUop,
  output logic       addi,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   waiting;

  assign state   = state_q;
  assign waiting = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};

  mem_wait_watchdog #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .waiting  (waiting),
    .mem_ready(mem_ready),
    .timeout  (mem_timeout)
  );

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADDR:  state_d = opcode[3] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_RCOMPL;
      S_ADDIEXEC: state_d = S_ADDICOMPL;
      default:    state_d = S_FETCH;
    endcase
    if (mem_timeout) state_d = S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUop       = ALUOP_ADD;
    addi        = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = SRCB_IMM_SH;
          illegal_op = !is_legal_op(opcode);
        end
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUop   = ALUOP_FUNCT;
        end
        S_RCOMPL: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUop       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_ADDIEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUop   = ALUOP_FUNCT;
          addi    = 1'b1;
        end
        S_ADDICOMPL: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed-vector scoreboard bench for multicycle_main_control, built with WAIT_LIMIT=4.
module tb_multicycle_main_control;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       addi;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } out_t;

  typedef struct {
    string tag;
    out_t  exp;
  } item_t;

  // Hand-written expected output sets, one per state / mem_ready situation.
  localparam out_t E_RST0  = '{state: 4'd0, default: '0};
  localparam out_t E_RST3  = '{state: 4'd3, default: '0};
  localparam out_t E_FRDY  = '{state: 4'd0, mem_read: 1'b1, alu_src_b: 2'b01,
                               ir_write: 1'b1, pc_write: 1'b1, default: '0};
  localparam out_t E_FWAIT = '{state: 4'd0, mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
  localparam out_t E_FTO   = '{state: 4'd0, mem_read: 1'b1, alu_src_b: 2'b01,
                               mem_timeout: 1'b1, default: '0};
  localparam out_t E_DEC   = '{state: 4'd1, alu_src_b: 2'b11, default: '0};
  localparam out_t E_DILL  = '{state: 4'd1, alu_src_b: 2'b11, illegal_op: 1'b1, default: '0};
  localparam out_t E_MA    = '{state: 4'd2, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam out_t E_MR    = '{state: 4'd3, mem_read: 1'b1, iord: 1'b1, default: '0};
  localparam out_t E_MWB   = '{state: 4'd4, reg_write: 1'b1, memto_reg: 1'b1,
                               instr_done: 1'b1, default: '0};
  localparam out_t E_MWW   = '{state: 4'd5, mem_write: 1'b1, iord: 1'b1, default: '0};
  localparam out_t E_MWR   = '{state: 4'd5, mem_write: 1'b1, iord: 1'b1,
                               instr_done: 1'b1, default: '0};
  localparam out_t E_MWTO  = '{state: 4'd5, mem_write: 1'b1, iord: 1'b1,
                               mem_timeout: 1'b1, default: '0};
  localparam out_t E_EX    = '{state: 4'd6, alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
  localparam out_t E_RC    = '{state: 4'd7, reg_write: 1'b1, reg_dst: 1'b1,
                               instr_done: 1'b1, default: '0};
  localparam out_t E_BR    = '{state: 4'd8, alu_src_a: 1'b1, alu_op: 2'b01, pc_write_cond: 1'b1,
                               pc_source: 2'b01, instr_done: 1'b1, default: '0};
  localparam out_t E_JP    = '{state: 4'd9, pc_write: 1'b1, pc_source: 2'b10,
                               instr_done: 1'b1, default: '0};
  localparam out_t E_AE    = '{state: 4'd10, alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 2'b10,
                               addi: 1'b1, default: '0};
  localparam out_t E_AC    = '{state: 4'd11, reg_write: 1'b1, instr_done: 1'b1, default: '0};

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUop, ALUSrcB;
  logic       addi, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op, mem_timeout;
  logic [3:0] state;

  item_t q[$];
  int    n_vec  = 0;
  int    n_miss = 0;
  out_t  act;

  always #5 clk = ~clk;

  multicycle_main_control #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .PCSource   (PCSource),
    .ALUop      (ALUop),
    .addi       (addi),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout),
    .state      (state)
  );

  always_comb begin
    act               = '0;
    act.state         = state;
    act.pc_write      = PCWrite;
    act.pc_write_cond = PCWriteCond;
    act.iord          = IorD;
    act.mem_read      = MemRead;
    act.mem_write     = MemWrite;
    act.memto_reg     = MemtoReg;
    act.ir_write      = IRWrite;
    act.pc_source     = PCSource;
    act.alu_op        = ALUop;
    act.addi          = addi;
    act.alu_src_a     = ALUSrcA;
    act.alu_src_b     = ALUSrcB;
    act.reg_write     = RegWrite;
    act.reg_dst       = RegDst;
    act.instr_done    = instr_done;
    act.illegal_op    = illegal_op;
    act.mem_timeout   = mem_timeout;
  end

  // Monitor: the DUT presents a full output set every cycle; check it mid-cycle.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        it = q.pop_front();
        n_vec++;
        if (act !== it.exp) begin
          n_miss++;
          $display("FAIL %s: got %h expected %h", it.tag, act, it.exp);
        end
      end
    end
  end

  // Drives one cycle of inputs, queues its expectation, then advances to just past the next edge.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic rdy, input out_t exp);
    item_t it;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    it.tag    = tag;
    it.exp    = exp;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = R;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("reset_hold", 1'b1, R, 1'b1, E_RST0);

    step("r_fetch",   1'b0, R, 1'b1, E_FRDY);
    step("r_decode",  1'b0, R, 1'b1, E_DEC);
    step("r_execute", 1'b0, R, 1'b1, E_EX);
    step("r_rcompl",  1'b0, R, 1'b1, E_RC);

    step("lw_fetch",   1'b0, LW, 1'b1, E_FRDY);
    step("lw_decode",  1'b0, LW, 1'b1, E_DEC);
    step("lw_memaddr", 1'b0, LW, 1'b1, E_MA);
    for (int i = 0; i < 3; i++) step("lw_stall", 1'b0, LW, 1'b0, E_MR);
    step("lw_memread", 1'b0, LW, 1'b1, E_MR);
    step("lw_memwb",   1'b0, LW, 1'b1, E_MWB);

    step("addi_fetch",  1'b0, ADI, 1'b1, E_FRDY);
    step("addi_decode", 1'b0, ADI, 1'b1, E_DEC);
    step("addi_exec",   1'b0, ADI, 1'b1, E_AE);
    step("addi_compl",  1'b0, ADI, 1'b1, E_AC);

    step("beq_fetch",  1'b0, BEQ, 1'b1, E_FRDY);
    step("beq_decode", 1'b0, BEQ, 1'b1, E_DEC);
    step("beq_branch", 1'b0, BEQ, 1'b1, E_BR);
    step("j_fetch",    1'b0, J,   1'b1, E_FRDY);
    step("j_decode",   1'b0, J,   1'b1, E_DEC);
    step("j_jump",     1'b0, J,   1'b1, E_JP);

    step("bad_fetch",  1'b0, BAD, 1'b1, E_FRDY);
    step("bad_decode", 1'b0, BAD, 1'b1, E_DILL);
    for (int i = 0; i < 4; i++) step("fetch_stall", 1'b0, BAD, 1'b0, E_FWAIT);
    step("fetch_timeout", 1'b0, BAD, 1'b0, E_FTO);

    step("sw_fetch",   1'b0, SW, 1'b1, E_FRDY);
    step("sw_decode",  1'b0, SW, 1'b1, E_DEC);
    step("sw_memaddr", 1'b0, SW, 1'b1, E_MA);
    for (int i = 0; i < 4; i++) step("sw_stall", 1'b0, SW, 1'b0, E_MWW);
    step("sw_timeout", 1'b0, SW, 1'b0, E_MWTO);
    step("post_timeout_fetch", 1'b0, SW, 1'b1, E_FRDY);

    step("sw2_decode",  1'b0, SW, 1'b1, E_DEC);
    step("sw2_memaddr", 1'b0, SW, 1'b1, E_MA);
    for (int i = 0; i < 4; i++) step("sw2_stall", 1'b0, SW, 1'b0, E_MWW);
    step("sw2_ready_at_limit", 1'b0, SW, 1'b1, E_MWR);
    step("sw2_back_fetch",     1'b0, LW, 1'b1, E_FRDY);

    step("lw3_decode",  1'b0, LW, 1'b1, E_DEC);
    step("lw3_memaddr", 1'b0, LW, 1'b1, E_MA);
    step("lw3_stall",   1'b0, LW, 1'b0, E_MR);
    step("reset_in_memread", 1'b1, LW, 1'b1, E_RST3);
    step("reset_to_fetch",   1'b1, LW, 1'b1, E_RST0);
    step("after_reset_fetch", 1'b0, R, 1'b1, E_FRDY);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d vectors still pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle datapath.
- Decodes the 6-bit opcode from IR and sequences Fetch/Decode/Execute/Memory/Writeback.
- Produces the 2-bit ALUop and addi flag consumed by ALU_ControlUnit, plus all datapath mux/enable strobes.
- Waits on a memory ready handshake; a watchdog aborts stalled accesses.

Parameters:
- WAIT_LIMIT, 255, max consecutive cycles a memory state may wait for mem_ready; 0 disables the watchdog.
- CNT_W, 8, width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  6  IR[31:26], stable from DECODE until instruction end
- mem_ready  input  1  memory has completed the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU zero
- IorD  output  1  0 = PC address, 1 = ALUOut address
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- MemtoReg  output  1  register write data from MDR
- IRWrite  output  1  IR load
- PCSource  output  2  00 ALU, 01 ALUOut, 10 jump target
- ALUop  output  2  to ALU_ControlUnit
- addi  output  1  to ALU_ControlUnit; forces add when ALUop=10
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- RegWrite  output  1  register file write
- RegDst  output  1  1 = rd, 0 = rt
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
- mem_timeout  output  1  one-cycle pulse when the watchdog fires
- state  output  4  current state, for debug

Behaviour:
- Opcodes:
  - RTYPE 000000
  - LW 100011
  - SW 101011
  - BEQ 000100
  - J 000010
  - ADDI 001000
- State encoding: FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, RCOMPL 7, BRANCH 8, JUMP 9, ADDIEXEC 10, ADDICOMPL 11. Codes 12-15 go to FETCH next cycle with all outputs 0.
- Reset:
  - Any rising edge with reset=1 sets state=FETCH and clears the wait counter.
  - While reset=1, every output is 0 (state output shows the registered value).
  - Reset mid-instruction aborts it with no further writes.
- Outputs are a Moore decode of state, gated by mem_ready where noted. Unlisted outputs are 0.
  - FETCH: MemRead=1, ALUSrcB=01, ALUop=00, PCSource=00; IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcB=11, ALUop=00.
  - MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - MEMREAD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
  - MEMWRITE: MemWrite=1, IorD=1, instr_done=mem_ready.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUop=10.
  - RCOMPL: RegWrite=1, RegDst=1, instr_done=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, instr_done=1.
  - JUMP: PCWrite=1, PCSource=10, instr_done=1.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUop=10, addi=1.
  - ADDICOMPL: RegWrite=1, RegDst=0, instr_done=1.
- Transitions:
  - FETCH to DECODE on mem_ready, else stay.
  - DECODE: LW/SW to MEMADDR, RTYPE to EXECUTE, BEQ to BRANCH, J to JUMP, ADDI to ADDIEXEC.
  - DECODE with any other opcode: go to FETCH and pulse illegal_op.
  - MEMADDR to MEMREAD if opcode[3]=0, else MEMWRITE.
  - MEMREAD to MEMWB on mem_ready, else stay.
  - MEMWRITE to FETCH on mem_ready, else stay.
  - EXECUTE to RCOMPL; ADDIEXEC to ADDICOMPL.
  - MEMWB, RCOMPL, BRANCH, JUMP, ADDICOMPL go to FETCH.
- Watchdog:
  - Wait counter increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Counter clears on mem_ready=1 or any state change.
  - If WAIT_LIMIT≠0 and counter reaches WAIT_LIMIT while mem_ready=0: pulse mem_timeout and go to FETCH next cycle. No IRWrite, PCWrite or RegWrite is issued.
  - mem_ready=1 on the limit cycle wins over the timeout.
- Latencies with mem_ready always 1: R-type 4 cycles, ADDI 4, LW 5, SW 4, BEQ 3, J 3.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - opcode constants
  - ALUop encodings (00 add, 01 sub, 10 funct)
  - ALUSrcB and PCSource encodings
  - 4-bit state localparams
- One sub-module: `mem_wait_watchdog` (counter, limit compare, timeout pulse).
- Next-state logic and output decode stay in the top module.

Test Plan:
- R-type, mem_ready=1, opcode 000000 from reset release: states 0→1→6→7→0. In state 6, ALUop=10 and addi=0. RegWrite=1 and RegDst=1 in state 7. instr_done pulses on cycle 4.
- LW with a 3-cycle MEMREAD stall: MemRead and IorD stay 1 for 4 cycles. MEMWB asserts RegWrite=1 and MemtoReg=1 exactly once. No mem_timeout.
- ADDI 001000: state 10 drives ALUop=10, addi=1, ALUSrcB=10. State 11 drives RegWrite=1, RegDst=0, then returns to FETCH.
- BEQ then J:
  - BEQ drives ALUop=01, PCWriteCond=1, PCSource=01 for one cycle.
  - J drives PCWrite=1, PCSource=10.
  - Each returns to FETCH.
- Opcode 111111 in DECODE: illegal_op pulses 1 cycle, next state FETCH, no RegWrite or MemWrite.
- WAIT_LIMIT=4 with SW and mem_ready held 0: mem_timeout pulses after 4 MEMWRITE cycles, then state=FETCH. Separately, reset asserted mid-MEMREAD forces all outputs 0 and state=FETCH on the next edge.
